waveform_capture: RTL

Threshold-triggered waveform capture stage sitting directly downstream of the 100-tap ADC delay line. It watches the live ADC sample for a threshold crossing and records a fixed-length window from the delay line's oldest tap, giving 100 pre-trigger samples. It then streams the window as bytes to the UART transmitter over a valid/ready handshake.

---
 rtl/capture_pkg.sv | 18 +
 rtl/waveform_capture_if.sv | 21 ++
 rtl/waveform_capture_ram.sv | 23 ++
 rtl/waveform_capture.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the threshold-triggered
// waveform capture stage.
package capture_pkg;

  localparam int DATA_W   = 14;
  localparam int PRE_TRIG = 100;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    SEND
  } state_e;

endpackage

// File: rtl/waveform_capture_if.sv
// Byte stream valid/ready link from the capture
// stage to the UART transmitter.
interface waveform_capture_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/waveform_capture_ram.sv
// Simple dual-port capture buffer: one synchronous
// write port, one registered read port.
module capture_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/waveform_capture.sv
// Threshold-triggered capture of a pre/post-trigger
// window, streamed out as header plus sample bytes.
module waveform_capture
  import capture_pkg::*;
#(
  parameter int DATA_W   = capture_pkg::DATA_W,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = capture_pkg::PRE_TRIG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_in,
  input  logic [DATA_W-1:0] delayed_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic              trig_falling,
  input  logic              arm,
  waveform_capture_if.master tx,
  output logic              busy,
  output logic              triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = 2 + 2 * DEPTH;
  localparam int BW = $clog2(NB + 1);
  localparam int FW = $clog2(PRE_TRIG + 1);

  state_e            state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [DATA_W-1:0] prev_q;
  logic              prev_ok_q, prev_ok_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              trig_q;

  logic              fill_done;
  logic              hit, trig;
  logic              xfer, load;
  logic              is_hi, is_lo;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] rdata;
  logic [15:0]       s16;
  logic [7:0]        nxt_byte;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (delayed_in),
    .raddr_i (raddr_q),
    .rdata_o (rdata)
  );

  assign fill_done = (fill_q == FW'(PRE_TRIG));
  assign s16       = 16'(rdata);

  assign hit = trig_falling
    ? (prev_q > threshold && adc_in <= threshold)
    : (prev_q < threshold && adc_in >= threshold);

  assign trig = (state_q == ARMED) && prev_ok_q && hit;

  assign xfer  = valid_q && tx.byte_ready;
  assign load  = (state_q == SEND)
              && (!valid_q || tx.byte_ready)
              && (bidx_q != BW'(NB));
  assign is_hi = (bidx_q >= BW'(2)) && !bidx_q[0];
  assign is_lo = (bidx_q >= BW'(2)) && bidx_q[0];

  always_comb begin
    nxt_byte = 8'h00;
    unique case (1'b1)
      bidx_q == BW'(0): nxt_byte = HDR0;
      bidx_q == BW'(1): nxt_byte = HDR1;
      is_hi:            nxt_byte = s16[15:8];
      is_lo:            nxt_byte = lo_q;
      default:          nxt_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_done ? fill_q : fill_q + FW'(1);
    prev_ok_d = prev_ok_q;
    wcnt_d    = wcnt_q;
    raddr_d   = raddr_q;
    bidx_d    = bidx_q;
    lo_d      = lo_q;
    data_d    = data_q;
    valid_d   = valid_q;
    we        = 1'b0;
    waddr     = wcnt_q;
    case (state_q)
      IDLE: begin
        if (arm && fill_done) begin
          state_d   = ARMED;
          prev_ok_d = 1'b0;
        end
      end
      ARMED: begin
        prev_ok_d = 1'b1;
        if (trig) begin
          state_d = CAPTURE;
          we      = 1'b1;
          waddr   = '0;
          wcnt_d  = AW'(1);
        end
      end
      CAPTURE: begin
        we      = 1'b1;
        wcnt_d  = wcnt_q + AW'(1);
        raddr_d = '0;
        bidx_d  = '0;
        if (wcnt_q == AW'(DEPTH - 1)) state_d = SEND;
      end
      SEND: begin
        if (xfer) valid_d = 1'b0;
        // Low byte is stashed so the read address can run one sample ahead
        if (load) begin
          valid_d = 1'b1;
          data_d  = nxt_byte;
          bidx_d  = bidx_q + BW'(1);
          if (is_hi) begin
            lo_d    = s16[7:0];
            raddr_d = raddr_q + AW'(1);
          end
        end
        if (xfer && bidx_q == BW'(NB)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      wcnt_q    <= '0;
      raddr_q   <= '0;
      bidx_q    <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      prev_q    <= adc_in;
      prev_ok_q <= prev_ok_d;
      wcnt_q    <= wcnt_d;
      raddr_q   <= raddr_d;
      bidx_q    <= bidx_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      trig_q    <= trig;
    end
  end

  assign tx.byte_data  = data_q;
  assign tx.byte_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign triggered     = trig_q;

endmodule
